// File: rtl/fetch_stage_hs_if.sv
// Instruction-memory request/grant/response channel between the fetch stage and imem.
interface fetch_stage_hs_if #(
  parameter int unsigned XLEN = 32
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [31:0]     imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_stage_hs.sv
// IF stage with IF/ID register: single-outstanding imem fetch, one-entry skid buffer,
// decode stall/flush and EX redirect with wrong-path response discard.
module fetch_stage_hs #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallD,
  input  logic             flushD,
  input  logic             pcselE,
  input  logic [XLEN-1:0]  ALUresE,
  fetch_stage_hs_if.master imem,
  output logic [31:0]      instrD,
  output logic [XLEN-1:0]  pcD,
  output logic [XLEN-1:0]  pc4D,
  output logic             validD,
  output logic             misalignE
);

  localparam int unsigned     ILEN      = 32;
  localparam logic [1:0]      S_ISSUE   = 2'd0;
  localparam logic [1:0]      S_WAIT    = 2'd1;
  localparam logic [1:0]      S_DISCARD = 2'd2;
  localparam logic [XLEN-1:0] PC_STEP   = XLEN'(4);

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] pc_f_q, pc_f_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            buf_valid_q, buf_valid_d;
  logic [ILEN-1:0] buf_instr_q, buf_instr_d;
  logic [XLEN-1:0] buf_pc_q, buf_pc_d;
  logic            valid_id_q, valid_id_d;
  logic [ILEN-1:0] instr_id_q, instr_id_d;
  logic [XLEN-1:0] pc_id_q, pc_id_d;
  logic [XLEN-1:0] pc4_id_q, pc4_id_d;

  logic            redirect;
  logic [XLEN-1:0] target;
  logic            req_c;
  logic            grant;
  logic            deliver;
  logic            capture;
  logic            unused_alures_lsb;

  assign redirect          = pcselE;
  assign target            = {ALUresE[XLEN-1:2], 2'b00};
  assign misalignE         = pcselE & ALUresE[1];
  assign unused_alures_lsb = ALUresE[0];

  // A parked instruction in the skid buffer blocks new requests.
  assign req_c          = (state_q == S_ISSUE) && !buf_valid_q;
  assign grant          = req_c && imem.imem_gnt;
  assign deliver        = (state_q == S_WAIT) && imem.imem_rvalid && !redirect;
  assign capture        = deliver && (stallD || flushD || buf_valid_q);
  assign imem.imem_req  = req_c;
  assign imem.imem_addr = pc_f_q;

  // Fetch FSM and PC.
  always_comb begin
    state_d  = state_q;
    pc_f_d   = pc_f_q;
    req_pc_d = req_pc_q;
    case (state_q)
      S_ISSUE: begin
        if (grant) begin
          if (redirect) begin
            state_d = S_DISCARD;
          end else begin
            req_pc_d = pc_f_q;
            pc_f_d   = pc_f_q + PC_STEP;
            state_d  = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (imem.imem_rvalid) begin
          state_d = S_ISSUE;
        end else if (redirect) begin
          state_d = S_DISCARD;
        end
      end
      S_DISCARD: begin
        if (imem.imem_rvalid) begin
          state_d = S_ISSUE;
        end
      end
      default: state_d = S_ISSUE;
    endcase
    if (redirect) begin
      pc_f_d = target;
    end
  end

  // Skid buffer: catches a delivered response that IF/ID cannot take this edge.
  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_instr_d = buf_instr_q;
    buf_pc_d    = buf_pc_q;
    if (redirect) begin
      buf_valid_d = 1'b0;
    end else if (capture) begin
      buf_valid_d = 1'b1;
      buf_instr_d = imem.imem_rdata;
      buf_pc_d    = req_pc_q;
    end else if (buf_valid_q && !stallD && !flushD) begin
      buf_valid_d = 1'b0;
    end
  end

  // IF/ID register update in priority order.
  always_comb begin
    valid_id_d = valid_id_q;
    instr_id_d = instr_id_q;
    pc_id_d    = pc_id_q;
    pc4_id_d   = pc4_id_q;
    if (redirect || flushD) begin
      valid_id_d = 1'b0;
      instr_id_d = NOP_INSTR;
    end else if (stallD) begin
      valid_id_d = valid_id_q;
    end else if (buf_valid_q) begin
      valid_id_d = 1'b1;
      instr_id_d = buf_instr_q;
      pc_id_d    = buf_pc_q;
      pc4_id_d   = buf_pc_q + PC_STEP;
    end else if (deliver) begin
      valid_id_d = 1'b1;
      instr_id_d = imem.imem_rdata;
      pc_id_d    = req_pc_q;
      pc4_id_d   = req_pc_q + PC_STEP;
    end else begin
      valid_id_d = 1'b0;
      instr_id_d = NOP_INSTR;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_ISSUE;
      pc_f_q      <= RESET_PC;
      req_pc_q    <= '0;
      buf_valid_q <= 1'b0;
      buf_instr_q <= NOP_INSTR;
      buf_pc_q    <= '0;
      valid_id_q  <= 1'b0;
      instr_id_q  <= NOP_INSTR;
      pc_id_q     <= '0;
      pc4_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      pc_f_q      <= pc_f_d;
      req_pc_q    <= req_pc_d;
      buf_valid_q <= buf_valid_d;
      buf_instr_q <= buf_instr_d;
      buf_pc_q    <= buf_pc_d;
      valid_id_q  <= valid_id_d;
      instr_id_q  <= instr_id_d;
      pc_id_q     <= pc_id_d;
      pc4_id_q    <= pc4_id_d;
    end
  end

  assign validD = valid_id_q;
  assign instrD = instr_id_q;
  assign pcD    = pc_id_q;
  assign pc4D   = pc4_id_q;

endmodule

// File: tb/tb_fetch_stage_hs.sv
// Bench for fetch_stage_hs: scripted scenarios plus a randomized run checked against
// a program-order stream model and a variable-latency memory model.
module tb_fetch_stage_hs;
  localparam int unsigned XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, stallD, flushD, pcselE;
  logic [31:0] ALUresE;
  logic [31:0] instrD, pcD, pc4D;
  logic        validD, misalignE;

  int checks = 0;
  int errors = 0;

  // memory model state
  logic [31:0] q_addr[$];
  int          q_ready[$];
  int          cyc = 0;
  int          gnt_pct = 0;
  int          lat_cfg = 1;
  bit          lat_rand = 1'b0;

  // program-order model
  logic [31:0] exp_pc = RESET_PC;
  int          entries = 0;

  fetch_stage_hs_if #(.XLEN(XLEN)) imem_if ();

  fetch_stage_hs #(.XLEN(XLEN), .RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .stallD(stallD), .flushD(flushD), .pcselE(pcselE),
    .ALUresE(ALUresE), .imem(imem_if), .instrD(instrD), .pcD(pcD), .pc4D(pc4D),
    .validD(validD), .misalignE(misalignE)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h00C0_FFEE;
  endfunction

  // One clock: record handshakes at the edge, advance, check new IF/ID entries, drive memory.
  task automatic tick();
    logic        pre_rst, pre_stall, pre_redir;
    logic [31:0] pre_tgt;
    int          lat;
    pre_rst   = rst;
    pre_stall = stallD;
    pre_redir = pcselE;
    pre_tgt   = {ALUresE[31:2], 2'b00};
    if (pre_rst) begin
      q_addr.delete();
      q_ready.delete();
    end else begin
      if (imem_if.imem_rvalid && q_addr.size() > 0) begin
        void'(q_addr.pop_front());
        void'(q_ready.pop_front());
      end
      if (imem_if.imem_req && imem_if.imem_gnt) begin
        checks++;
        if (q_addr.size() != 0) begin
          errors++;
          $display("FAIL outstanding: got %0d pending at grant of %h, need 0", q_addr.size(), imem_if.imem_addr);
        end
        lat = lat_rand ? int'($urandom_range(3, 1)) : lat_cfg;
        q_addr.push_back(imem_if.imem_addr);
        q_ready.push_back(cyc + lat);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (pre_rst) begin
      exp_pc = RESET_PC;
    end else if (pre_redir) begin
      exp_pc = pre_tgt;
    end else if (validD && !pre_stall) begin
      checks++;
      if (pcD !== exp_pc || instrD !== mem_of(exp_pc) || pc4D !== exp_pc + 32'd4) begin
        errors++;
        $display("FAIL stream: got pcD=%h instrD=%h pc4D=%h, need pcD=%h instrD=%h pc4D=%h",
                 pcD, instrD, pc4D, exp_pc, mem_of(exp_pc), exp_pc + 32'd4);
      end
      exp_pc = exp_pc + 32'd4;
      entries++;
    end
    imem_if.imem_rvalid = (q_addr.size() > 0) && (cyc >= q_ready[0]);
    imem_if.imem_rdata  = imem_if.imem_rvalid ? mem_of(q_addr[0]) : 32'hDEAD_BEEF;
    imem_if.imem_gnt    = (int'($urandom_range(99, 0)) < gnt_pct);
  endtask

  task automatic do_reset();
    stallD = 1'b0; flushD = 1'b0; pcselE = 1'b0; ALUresE = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    gnt_pct = 0; lat_rand = 1'b0; lat_cfg = 1;
    do_reset();
    checks++;
    if ({validD, instrD, pcD, pc4D, imem_if.imem_req, imem_if.imem_addr, misalignE} !==
        {1'b0, NOP, 32'h0, 32'h0, 1'b1, RESET_PC, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: got v=%b i=%h pc=%h pc4=%h req=%b addr=%h mis=%b, need v=0 i=%h pc=0 pc4=0 req=1 addr=%h mis=0",
               validD, instrD, pcD, pc4D, imem_if.imem_req, imem_if.imem_addr, misalignE, NOP, RESET_PC);
    end
    tick();
    checks++;
    if ({imem_if.imem_req, imem_if.imem_addr, validD} !== {1'b1, RESET_PC, 1'b0}) begin
      errors++;
      $display("FAIL reset_no_gnt: got req=%b addr=%h v=%b, need req=1 addr=%h v=0",
               imem_if.imem_req, imem_if.imem_addr, validD, RESET_PC);
    end
  endtask

  task automatic test_basic();
    logic [31:0] a;
    gnt_pct = 100; lat_rand = 1'b0; lat_cfg = 1;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      a = 32'(4 * i);
      checks++;
      if ({imem_if.imem_req, imem_if.imem_addr} !== {1'b1, a}) begin
        errors++;
        $display("FAIL basic_issue: got req=%b addr=%h, need req=1 addr=%h", imem_if.imem_req, imem_if.imem_addr, a);
      end
      tick();
      checks++;
      if ({imem_if.imem_req, validD, instrD} !== {1'b0, 1'b0, NOP}) begin
        errors++;
        $display("FAIL basic_wait: got req=%b v=%b i=%h, need req=0 v=0 i=%h", imem_if.imem_req, validD, instrD, NOP);
      end
      tick();
      checks++;
      if ({validD, instrD, pcD, pc4D} !== {1'b1, mem_of(a), a, a + 32'd4}) begin
        errors++;
        $display("FAIL basic_id: got v=%b i=%h pc=%h pc4=%h, need v=1 i=%h pc=%h pc4=%h",
                 validD, instrD, pcD, pc4D, mem_of(a), a, a + 32'd4);
      end
    end
    checks++;
    if ({imem_if.imem_req, imem_if.imem_addr} !== {1'b1, 32'h0000_000C}) begin
      errors++;
      $display("FAIL basic_next: got req=%b addr=%h, need req=1 addr=0000000c", imem_if.imem_req, imem_if.imem_addr);
    end
  endtask

  task automatic test_stall();
    gnt_pct = 100; lat_rand = 1'b0; lat_cfg = 1;
    do_reset();
    for (int i = 0; i < 4; i++) tick();
    stallD = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if ({imem_if.imem_req, validD, pcD} !== {1'b0, 1'b1, 32'h4}) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got req=%b v=%b pc=%h, need req=0 v=1 pc=00000004", k, imem_if.imem_req, validD, pcD);
      end
    end
    stallD = 1'b0;
    tick();
    checks++;
    if ({validD, instrD, pcD, pc4D, imem_if.imem_req, imem_if.imem_addr} !==
        {1'b1, mem_of(32'h8), 32'h8, 32'hC, 1'b1, 32'hC}) begin
      errors++;
      $display("FAIL stall_release: got v=%b i=%h pc=%h pc4=%h req=%b addr=%h, need v=1 i=%h pc=8 pc4=c req=1 addr=c",
               validD, instrD, pcD, pc4D, imem_if.imem_req, imem_if.imem_addr, mem_of(32'h8));
    end
    tick();
    checks++;
    if ({validD, imem_if.imem_req} !== 2'b00) begin
      errors++;
      $display("FAIL stall_nodup: got v=%b req=%b, need v=0 req=0", validD, imem_if.imem_req);
    end
    tick();
    checks++;
    if ({validD, pcD, instrD} !== {1'b1, 32'hC, mem_of(32'hC)}) begin
      errors++;
      $display("FAIL stall_resume: got v=%b pc=%h i=%h, need v=1 pc=0000000c i=%h", validD, pcD, instrD, mem_of(32'hC));
    end
  endtask

  task automatic test_redirect_wait();
    gnt_pct = 0; lat_rand = 1'b0; lat_cfg = 1;
    do_reset();
    pcselE = 1'b1; ALUresE = 32'h10;
    #1;
    checks++;
    if (misalignE !== 1'b0) begin
      errors++;
      $display("FAIL misalign_low: got %b need 0", misalignE);
    end
    tick();
    pcselE = 1'b0; ALUresE = '0;
    imem_if.imem_gnt = 1'b1; lat_cfg = 4;
    tick();
    imem_if.imem_gnt = 1'b0; lat_cfg = 1;
    pcselE = 1'b1; ALUresE = 32'h103;
    #1;
    checks++;
    if (misalignE !== 1'b1) begin
      errors++;
      $display("FAIL misalign_high: got %b need 1", misalignE);
    end
    tick();
    pcselE = 1'b0; ALUresE = '0; gnt_pct = 100;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({imem_if.imem_req, validD} !== 2'b00) begin
        errors++;
        $display("FAIL redir_wait_drop[%0d]: got req=%b v=%b, need req=0 v=0", k, imem_if.imem_req, validD);
      end
      tick();
    end
    checks++;
    if ({imem_if.imem_req, imem_if.imem_addr, validD} !== {1'b1, 32'h100, 1'b0}) begin
      errors++;
      $display("FAIL redir_wait_addr: got req=%b addr=%h v=%b, need req=1 addr=00000100 v=0",
               imem_if.imem_req, imem_if.imem_addr, validD);
    end
    tick();
    tick();
    checks++;
    if ({validD, instrD, pcD, pc4D} !== {1'b1, mem_of(32'h100), 32'h100, 32'h104}) begin
      errors++;
      $display("FAIL redir_wait_id: got v=%b i=%h pc=%h pc4=%h, need v=1 i=%h pc=100 pc4=104",
               validD, instrD, pcD, pc4D, mem_of(32'h100));
    end
  endtask

  task automatic test_redirect_grant();
    gnt_pct = 0; lat_rand = 1'b0; lat_cfg = 1;
    do_reset();
    pcselE = 1'b1; ALUresE = 32'h20;
    tick();
    checks++;
    if ({imem_if.imem_req, imem_if.imem_addr} !== {1'b1, 32'h20}) begin
      errors++;
      $display("FAIL redir_gnt_addr20: got req=%b addr=%h, need req=1 addr=00000020", imem_if.imem_req, imem_if.imem_addr);
    end
    imem_if.imem_gnt = 1'b1; ALUresE = 32'h40; lat_cfg = 2;
    tick();
    pcselE = 1'b0; ALUresE = '0; lat_cfg = 1; gnt_pct = 100;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({imem_if.imem_req, validD, instrD} !== {1'b0, 1'b0, NOP}) begin
        errors++;
        $display("FAIL redir_gnt_discard[%0d]: got req=%b v=%b i=%h, need req=0 v=0 i=%h", k, imem_if.imem_req, validD, instrD, NOP);
      end
      tick();
    end
    checks++;
    if ({imem_if.imem_req, imem_if.imem_addr, validD, instrD} !== {1'b1, 32'h40, 1'b0, NOP}) begin
      errors++;
      $display("FAIL redir_gnt_addr40: got req=%b addr=%h v=%b i=%h, need req=1 addr=00000040 v=0 i=%h",
               imem_if.imem_req, imem_if.imem_addr, validD, instrD, NOP);
    end
    tick();
    tick();
    checks++;
    if ({validD, instrD, pcD} !== {1'b1, mem_of(32'h40), 32'h40}) begin
      errors++;
      $display("FAIL redir_gnt_id: got v=%b i=%h pc=%h, need v=1 i=%h pc=00000040", validD, instrD, pcD, mem_of(32'h40));
    end
  endtask

  task automatic test_flush();
    gnt_pct = 0; lat_rand = 1'b0; lat_cfg = 1;
    do_reset();
    pcselE = 1'b1; ALUresE = 32'h14;
    tick();
    pcselE = 1'b0; ALUresE = '0;
    imem_if.imem_gnt = 1'b1;
    tick();
    flushD = 1'b1;
    tick();
    flushD = 1'b0;
    checks++;
    if ({validD, instrD, pcD, imem_if.imem_req} !== {1'b0, NOP, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL flush_bubble: got v=%b i=%h pc=%h req=%b, need v=0 i=%h pc=0 req=0",
               validD, instrD, pcD, imem_if.imem_req, NOP);
    end
    tick();
    checks++;
    if ({validD, instrD, pcD, pc4D, imem_if.imem_req, imem_if.imem_addr} !==
        {1'b1, mem_of(32'h14), 32'h14, 32'h18, 1'b1, 32'h18}) begin
      errors++;
      $display("FAIL flush_reload: got v=%b i=%h pc=%h pc4=%h req=%b addr=%h, need v=1 i=%h pc=14 pc4=18 req=1 addr=18",
               validD, instrD, pcD, pc4D, imem_if.imem_req, imem_if.imem_addr, mem_of(32'h14));
    end
  endtask

  task automatic test_reset_mid();
    gnt_pct = 100; lat_rand = 1'b0; lat_cfg = 1;
    do_reset();
    for (int i = 0; i < 4; i++) tick();
    stallD = 1'b1; lat_cfg = 3;
    tick();
    checks++;
    if ({validD, pcD, imem_if.imem_req} !== {1'b1, 32'h4, 1'b0}) begin
      errors++;
      $display("FAIL rstmid_setup: got v=%b pc=%h req=%b, need v=1 pc=4 req=0", validD, pcD, imem_if.imem_req);
    end
    rst = 1'b1; gnt_pct = 0;
    tick();
    rst = 1'b0; stallD = 1'b0; lat_cfg = 1;
    checks++;
    if ({validD, instrD, pcD, pc4D, imem_if.imem_req, imem_if.imem_addr} !==
        {1'b0, NOP, 32'h0, 32'h0, 1'b1, RESET_PC}) begin
      errors++;
      $display("FAIL rstmid_state: got v=%b i=%h pc=%h pc4=%h req=%b addr=%h, need v=0 i=%h pc=0 pc4=0 req=1 addr=%h",
               validD, instrD, pcD, pc4D, imem_if.imem_req, imem_if.imem_addr, NOP, RESET_PC);
    end
    imem_if.imem_rvalid = 1'b1; imem_if.imem_rdata = 32'hBAD0_BAD0;
    tick();
    checks++;
    if ({validD, instrD, imem_if.imem_req, imem_if.imem_addr} !== {1'b0, NOP, 1'b1, RESET_PC}) begin
      errors++;
      $display("FAIL rstmid_stale: got v=%b i=%h req=%b addr=%h, need v=0 i=%h req=1 addr=%h",
               validD, instrD, imem_if.imem_req, imem_if.imem_addr, NOP, RESET_PC);
    end
    imem_if.imem_gnt = 1'b1;
    tick();
    tick();
    checks++;
    if ({validD, instrD, pcD} !== {1'b1, mem_of(RESET_PC), RESET_PC}) begin
      errors++;
      $display("FAIL rstmid_refetch: got v=%b i=%h pc=%h, need v=1 i=%h pc=%h", validD, instrD, pcD, mem_of(RESET_PC), RESET_PC);
    end
  endtask

  task automatic test_wrap();
    gnt_pct = 0; lat_rand = 1'b0; lat_cfg = 1;
    do_reset();
    pcselE = 1'b1; ALUresE = 32'hFFFF_FFFE;
    #1;
    checks++;
    if (misalignE !== 1'b1) begin
      errors++;
      $display("FAIL wrap_misalign: got %b need 1", misalignE);
    end
    tick();
    pcselE = 1'b0; ALUresE = '0;
    checks++;
    if (imem_if.imem_addr !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL wrap_target: got %h need fffffffc", imem_if.imem_addr);
    end
    imem_if.imem_gnt = 1'b1;
    tick();
    tick();
    checks++;
    if ({validD, instrD, pcD, pc4D, imem_if.imem_req, imem_if.imem_addr} !==
        {1'b1, mem_of(32'hFFFF_FFFC), 32'hFFFF_FFFC, 32'h0, 1'b1, 32'h0}) begin
      errors++;
      $display("FAIL wrap_id: got v=%b i=%h pc=%h pc4=%h req=%b addr=%h, need v=1 i=%h pc=fffffffc pc4=0 req=1 addr=0",
               validD, instrD, pcD, pc4D, imem_if.imem_req, imem_if.imem_addr, mem_of(32'hFFFF_FFFC));
    end
  endtask

  task automatic test_random();
    logic [31:0] addr_now;
    gnt_pct = 70; lat_rand = 1'b1;
    do_reset();
    entries = 0;
    for (int n = 0; n < 3000; n++) begin
      stallD  = (int'($urandom_range(99, 0)) < 20);
      flushD  = (int'($urandom_range(99, 0)) < 6);
      pcselE  = (int'($urandom_range(99, 0)) < 3);
      ALUresE = $urandom_range(32'h0000_0FFF, 0);
      #1;
      checks++;
      if (misalignE !== (pcselE & ALUresE[1])) begin
        errors++;
        $display("FAIL rand_misalign: got %b need %b (ALUresE=%h)", misalignE, pcselE & ALUresE[1], ALUresE);
      end
      addr_now = imem_if.imem_addr;
      checks++;
      if (addr_now[1:0] !== 2'b00) begin
        errors++;
        $display("FAIL rand_align: got addr=%h need low bits 00", addr_now);
      end
      tick();
    end
    stallD = 1'b0; flushD = 1'b0; pcselE = 1'b0; lat_rand = 1'b0;
    checks++;
    if (entries < 150) begin
      errors++;
      $display("FAIL rand_progress: got %0d delivered instructions, need at least 150", entries);
    end
  endtask

  initial begin
    rst = 1'b1; stallD = 1'b0; flushD = 1'b0; pcselE = 1'b0; ALUresE = '0;
    imem_if.imem_gnt = 1'b0; imem_if.imem_rvalid = 1'b0; imem_if.imem_rdata = '0;
    test_reset();
    test_basic();
    test_stall();
    test_redirect_wait();
    test_redirect_grant();
    test_flush();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
